tournament_resolve_queue: RTL and testbench
===========================================

# tournament_resolve_queue

In-order queue of in-flight branch predictions, sitting between the tournament predictor and its table-update ports. At prediction time it captures the BHT index, the global history, both component predictions, the choice counter and the final prediction. When the oldest branch resolves as correct or incorrect, it reconstructs the actual outcome and emits a registered update record for the GHR, the local/global tables and the choice predictor. This replaces ad hoc delay registers with a properly tracked, flushable structure.

## Interface
- bht_idx_width_p, 10, BHT index width
- ghist_width_p, 12, global history width
- depth_p, 4, queue entries (power of two, ≥2)
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- alloc_v_i  in  1  prediction issued this cycle
- alloc_ready_o  out  1  queue not full
- alloc_idx_i  in  bht_idx_width_p  BHT index of the branch
- alloc_ghist_i  in  ghist_width_p  global history used for the prediction
- alloc_gp_i  in  1  global component prediction
- alloc_lp_i  in  1  local component prediction
- alloc_choice_i  in  2  choice counter value; ≥2 selects global
- alloc_final_i  in  1  final prediction issued
- res_v_i  in  1  oldest branch resolved
- correct_i  in  1  oldest branch's final prediction was correct
- flush_i  in  1  discard all unresolved entries
- upd_v_o  out  1  update record valid (one-cycle pulse)
- upd_idx_o  out  bht_idx_width_p  index of resolved branch
- upd_ghist_o  out  ghist_width_p  history of resolved branch
- upd_taken_o  out  1  actual outcome
- upd_gp_correct_o / upd_lp_correct_o  out  1 each  component prediction matched outcome
- upd_choice_inc_o / upd_choice_dec_o  out  1 each  move choice counter toward global / local
- count_o  out  $clog2(depth_p)+1  occupied entries
- err_o  out  1  sticky underflow/overflow flag

## Operation
- Circular buffer with head and tail pointers of width $clog2(depth_p). Pointers wrap modulo depth_p. A separate count register tracks occupancy.
- Allocate: when alloc_v_i=1, count<depth_p and flush_i=0, write all alloc fields at the tail, then tail+1.
- alloc_v_i=1 while full: the entry is dropped and err_o is set.
- Resolve: when res_v_i=1 and count>0 (count sampled before this cycle's allocate), pop the head. The record is computed as follows:
  - taken = correct_i ? final : ~final
  - gp_correct = (gp == taken)
  - lp_correct = (lp == taken)
  - inc = gp_correct & ~lp_correct
  - dec = lp_correct & ~gp_correct
  - inc and dec are never both 1.
- res_v_i=1 with count==0: ignored, no update, err_o set.
  - This holds even when an allocate happens in the same cycle. There is no allocate-to-resolve bypass.
- Simultaneous allocate and resolve with 0<count<depth_p: both happen and count is unchanged.
- Simultaneous allocate and resolve when full: the allocate is dropped because alloc_ready_o=0. The resolve proceeds.
- Flush: count, head and tail are reset to 0.
  - A resolve in the same cycle is still honoured, and its update is emitted next cycle.
  - An allocate in the same cycle is dropped without setting err_o.
- err_o is cleared only by reset_i.

## Timing
- alloc_ready_o = (count != depth_p), driven from registered count only. It has no combinational path from res_v_i.
- An entry written in cycle N can be resolved in cycle N+1 or later.
- Update latency: a resolve accepted at edge N drives upd_* at N+1 for exactly one cycle. upd_v_o=0 in every other cycle.
- Data outputs hold their last value when upd_v_o=0.
- count_o reflects state after the most recent edge.
- Reset (asynchronous, immediate): count_o=0, alloc_ready_o=1, err_o=0. All upd_* outputs are 0, including upd_v_o. Pointers are 0.
- Reset asserted mid-operation discards all entries and any pending update pulse.

## Test plan
- Single branch: allocate idx=0x155, ghist=0xABC, gp=1, lp=0, choice=3, final=1; next cycle resolve with correct_i=0 -> one cycle later upd_v_o=1, idx=0x155, ghist=0xABC, taken=0, gp_correct=0, lp_correct=1, dec=1, inc=0.
- Fill/full: 4 allocates -> count_o=4 and alloc_ready_o=0. A 5th allocate is dropped and err_o=1. Four resolves then emit four updates in allocation order (idx 1,2,3,4), and count_o returns to 0.
- Wrap-around: 10 interleaved allocate+resolve pairs with depth_p=4 -> updates arrive in order with correct idx, and count_o never exceeds 2.
- Simultaneous allocate+resolve at count=2 -> count_o stays 2, the head update is emitted, and the new entry is resolved last.
- Underflow and flush: resolve on empty -> no upd_v_o, err_o=1. With 3 entries, flush+resolve in the same cycle -> one update for the head, then count_o=0 and alloc_ready_o=1.
- Async reset mid-stream with 2 entries and a pending update -> all outputs go to 0 immediately, and no upd_v_o pulse follows.

Source files
------------

// File: rtl/tournament_resolve_queue.sv
// In-order queue of in-flight tournament-predictor branches. Captures prediction
// state at issue and emits a registered table-update record when the head resolves.

module tournament_resolve_queue_entry #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] r_q;

  // Payload storage only; validity is tracked by head/tail/count in the parent.
  always_ff @(posedge clk_i) begin
    if (we_i) r_q <= d_i;
  end

  assign q_o = r_q;
endmodule

module tournament_resolve_queue #(
  parameter int bht_idx_width_p = 10,
  parameter int ghist_width_p   = 12,
  parameter int depth_p         = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       alloc_v_i,
  output logic                       alloc_ready_o,
  input  logic [bht_idx_width_p-1:0] alloc_idx_i,
  input  logic [ghist_width_p-1:0]   alloc_ghist_i,
  input  logic                       alloc_gp_i,
  input  logic                       alloc_lp_i,
  input  logic [1:0]                 alloc_choice_i,
  input  logic                       alloc_final_i,
  input  logic                       res_v_i,
  input  logic                       correct_i,
  input  logic                       flush_i,
  output logic                       upd_v_o,
  output logic [bht_idx_width_p-1:0] upd_idx_o,
  output logic [ghist_width_p-1:0]   upd_ghist_o,
  output logic                       upd_taken_o,
  output logic                       upd_gp_correct_o,
  output logic                       upd_lp_correct_o,
  output logic                       upd_choice_inc_o,
  output logic                       upd_choice_dec_o,
  output logic [$clog2(depth_p):0]   count_o,
  output logic                       err_o
);
  localparam int PW = $clog2(depth_p);
  localparam int CW = PW + 1;
  localparam int EW = bht_idx_width_p + ghist_width_p + 5;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_p);

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_err;

  logic                       r_upd_v;
  logic [bht_idx_width_p-1:0] r_upd_idx;
  logic [ghist_width_p-1:0]   r_upd_ghist;
  logic                       r_upd_taken, r_upd_gpc, r_upd_lpc, r_upd_inc, r_upd_dec;

  logic w_full, w_empty, w_alloc, w_res, w_err_set;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  // Flush wins over allocate, and a dropped-by-flush allocate is not an error.
  assign w_alloc = alloc_v_i & ~flush_i & ~w_full;
  // Resolve uses the pre-edge count: no bypass from a same-cycle allocate.
  assign w_res   = res_v_i & ~w_empty;
  assign w_err_set = (alloc_v_i & ~flush_i & w_full) | (res_v_i & w_empty);

  logic [EW-1:0]              w_ent_d;
  logic [depth_p-1:0][EW-1:0] w_ent_q;
  logic [EW-1:0]              w_head_ent;

  assign w_ent_d = {alloc_idx_i, alloc_ghist_i, alloc_gp_i, alloc_lp_i,
                    alloc_final_i, alloc_choice_i};

  for (genvar g = 0; g < depth_p; g++) begin : g_ent
    tournament_resolve_queue_entry #(.W(EW)) u_ent (
      .clk_i (clk_i),
      .we_i  (w_alloc && (r_tail == PW'(g))),
      .d_i   (w_ent_d),
      .q_o   (w_ent_q[g])
    );
  end

  assign w_head_ent = w_ent_q[r_head];

  logic [bht_idx_width_p-1:0] w_h_idx;
  logic [ghist_width_p-1:0]   w_h_ghist;
  logic                       w_h_gp, w_h_lp, w_h_final;
  logic [1:0]                 w_h_choice;
  logic                       w_unused_choice;

  assign {w_h_idx, w_h_ghist, w_h_gp, w_h_lp, w_h_final, w_h_choice} = w_head_ent;
  // The stored choice value is kept with the entry but the update rule needs only
  // the component-correctness pair.
  assign w_unused_choice = ^w_h_choice;

  logic w_taken, w_gpc, w_lpc;

  assign w_taken = correct_i ? w_h_final : ~w_h_final;
  assign w_gpc   = (w_h_gp == w_taken);
  assign w_lpc   = (w_h_lp == w_taken);

  always_comb begin
    w_count_nxt = r_count;
    if (flush_i) begin
      w_count_nxt = '0;
    end else begin
      case ({w_alloc, w_res})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (flush_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_res)   r_head <= r_head + PW'(1);
        if (w_alloc) r_tail <= r_tail + PW'(1);
      end
    end
  end

  // Update record: one-cycle valid pulse, data held between pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_upd_v     <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_ghist <= '0;
      r_upd_taken <= 1'b0;
      r_upd_gpc   <= 1'b0;
      r_upd_lpc   <= 1'b0;
      r_upd_inc   <= 1'b0;
      r_upd_dec   <= 1'b0;
    end else begin
      r_upd_v <= w_res;
      if (w_res) begin
        r_upd_idx   <= w_h_idx;
        r_upd_ghist <= w_h_ghist;
        r_upd_taken <= w_taken;
        r_upd_gpc   <= w_gpc;
        r_upd_lpc   <= w_lpc;
        r_upd_inc   <= w_gpc & ~w_lpc;
        r_upd_dec   <= w_lpc & ~w_gpc;
      end
    end
  end

  assign alloc_ready_o    = ~w_full;
  assign count_o          = r_count;
  assign err_o            = r_err;
  assign upd_v_o          = r_upd_v;
  assign upd_idx_o        = r_upd_idx;
  assign upd_ghist_o      = r_upd_ghist;
  assign upd_taken_o      = r_upd_taken;
  assign upd_gp_correct_o = r_upd_gpc;
  assign upd_lp_correct_o = r_upd_lpc;
  assign upd_choice_inc_o = r_upd_inc;
  assign upd_choice_dec_o = r_upd_dec;
endmodule

// File: tb/tb_tournament_resolve_queue.sv
// Bench for tournament_resolve_queue: record-rule vector table plus scoreboarded
// sequences for fill, wrap, simultaneous ops, underflow, flush and async reset.

module tb_tournament_resolve_queue;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        alloc_v_i = 1'b0;
  logic        alloc_ready_o;
  logic [9:0]  alloc_idx_i = '0;
  logic [11:0] alloc_ghist_i = '0;
  logic        alloc_gp_i = 1'b0;
  logic        alloc_lp_i = 1'b0;
  logic [1:0]  alloc_choice_i = '0;
  logic        alloc_final_i = 1'b0;
  logic        res_v_i = 1'b0;
  logic        correct_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        upd_v_o;
  logic [9:0]  upd_idx_o;
  logic [11:0] upd_ghist_o;
  logic        upd_taken_o, upd_gp_correct_o, upd_lp_correct_o;
  logic        upd_choice_inc_o, upd_choice_dec_o;
  logic [2:0]  count_o;
  logic        err_o;

  tournament_resolve_queue #(
    .bht_idx_width_p(10), .ghist_width_p(12), .depth_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o),
    .alloc_idx_i(alloc_idx_i), .alloc_ghist_i(alloc_ghist_i),
    .alloc_gp_i(alloc_gp_i), .alloc_lp_i(alloc_lp_i),
    .alloc_choice_i(alloc_choice_i), .alloc_final_i(alloc_final_i),
    .res_v_i(res_v_i), .correct_i(correct_i), .flush_i(flush_i),
    .upd_v_o(upd_v_o), .upd_idx_o(upd_idx_o), .upd_ghist_o(upd_ghist_o),
    .upd_taken_o(upd_taken_o), .upd_gp_correct_o(upd_gp_correct_o),
    .upd_lp_correct_o(upd_lp_correct_o), .upd_choice_inc_o(upd_choice_inc_o),
    .upd_choice_dec_o(upd_choice_dec_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [9:0] idx; logic [11:0] gh; bit gp, lp, fin; } ent_t;
  typedef struct { logic [9:0] idx; logic [11:0] gh; bit taken, gpc, lpc, inc, dec; } rec_t;
  typedef struct {
    logic [9:0] idx; logic [11:0] gh; bit gp, lp, fin, cor;
    bit taken, gpc, lpc, inc, dec;
  } vec_t;

  ent_t m_q[$];
  rec_t exp_q[$];
  bit   m_err = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_upd_v"}, 32'(upd_v_o), 0);
    chk({tag, "_upd_idx"}, 32'(upd_idx_o), 0);
    chk({tag, "_upd_ghist"}, 32'(upd_ghist_o), 0);
    chk({tag, "_upd_flags"}, 32'({upd_taken_o, upd_gp_correct_o, upd_lp_correct_o,
                                  upd_choice_inc_o, upd_choice_dec_o}), 0);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_ready"}, 32'(alloc_ready_o), 1);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  // One clock cycle: drive inputs, advance the reference queue, then check the DUT
  // just after the edge against the scoreboard and the model state.
  task automatic cyc(input bit a, input logic [9:0] idx, input logic [11:0] gh,
                     input bit gp, input bit lp, input logic [1:0] ch, input bit fin,
                     input bit r, input bit c, input bit f);
    int   sz;
    bit   r_ok, a_ok;
    ent_t e;
    rec_t x;
    alloc_v_i = a; alloc_idx_i = idx; alloc_ghist_i = gh; alloc_gp_i = gp;
    alloc_lp_i = lp; alloc_choice_i = ch; alloc_final_i = fin;
    res_v_i = r; correct_i = c; flush_i = f;
    sz   = m_q.size();
    r_ok = r && (sz > 0);
    a_ok = a && !f && (sz < 4);
    if ((r && sz == 0) || (a && !f && sz == 4)) m_err = 1'b1;
    if (r_ok) begin
      e = m_q.pop_front();
      x.idx = e.idx; x.gh = e.gh;
      x.taken = c ? e.fin : ~e.fin;
      x.gpc = (e.gp == x.taken);
      x.lpc = (e.lp == x.taken);
      x.inc = x.gpc && !x.lpc;
      x.dec = x.lpc && !x.gpc;
      exp_q.push_back(x);
    end
    if (f) m_q.delete();
    if (a_ok) begin
      e.idx = idx; e.gh = gh; e.gp = gp; e.lp = lp; e.fin = fin;
      m_q.push_back(e);
    end
    @(posedge clk_i); #1;
    if (upd_v_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL upd_unexpected: got upd_v_o=1 idx=0x%0h, want no update", upd_idx_o);
      end else begin
        x = exp_q.pop_front();
        chk("upd_idx", 32'(upd_idx_o), 32'(x.idx));
        chk("upd_ghist", 32'(upd_ghist_o), 32'(x.gh));
        chk("upd_flags", 32'({upd_taken_o, upd_gp_correct_o, upd_lp_correct_o,
                              upd_choice_inc_o, upd_choice_dec_o}),
            32'({x.taken, x.gpc, x.lpc, x.inc, x.dec}));
      end
    end
    chk("upd_missing", 32'(exp_q.size()), 0);
    chk("count", 32'(count_o), 32'(m_q.size()));
    chk("ready", 32'(alloc_ready_o), 32'(m_q.size() != 4));
    chk("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic alloc(input logic [9:0] idx, input logic [11:0] gh,
                       input bit gp, input bit lp, input bit fin);
    cyc(1, idx, gh, gp, lp, 2'd3, fin, 0, 0, 0);
  endtask

  task automatic resolve(input bit c);
    cyc(0, '0, '0, 0, 0, 2'd0, 0, 1, c, 0);
  endtask

  task automatic idle();
    cyc(0, '0, '0, 0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b1;
    #1;
    chk_reset_state(tag);
    m_q.delete(); exp_q.delete(); m_err = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    // {idx, ghist, gp, lp, final, correct} -> {taken, gp_ok, lp_ok, inc, dec}
    vt[0] = '{10'h155, 12'hABC, 1, 0, 1, 0, 0, 0, 1, 0, 1};
    vt[1] = '{10'h0A1, 12'h111, 1, 0, 1, 1, 1, 1, 0, 1, 0};
    vt[2] = '{10'h0A2, 12'h222, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    vt[3] = '{10'h0A3, 12'h333, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vt[4] = '{10'h0A4, 12'h444, 0, 1, 1, 1, 1, 0, 1, 0, 1};
    vt[5] = '{10'h0A5, 12'h555, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    vt[6] = '{10'h0A6, 12'h666, 1, 0, 0, 0, 1, 1, 0, 1, 0};
    vt[7] = '{10'h3FF, 12'hFFF, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    #1 reset_i = 1'b1;
    #1 chk_reset_state("por");
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 1'b0;

    // Record-rule table: each branch allocated then resolved the next cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(1, vt[i].idx, vt[i].gh, vt[i].gp, vt[i].lp, 2'(i), vt[i].fin, 0, 0, 0);
      resolve(vt[i].cor);
      chk("vec_v", 32'(upd_v_o), 1);
      chk("vec_idx", 32'(upd_idx_o), 32'(vt[i].idx));
      chk("vec_ghist", 32'(upd_ghist_o), 32'(vt[i].gh));
      chk("vec_flags", 32'({upd_taken_o, upd_gp_correct_o, upd_lp_correct_o,
                            upd_choice_inc_o, upd_choice_dec_o}),
          32'({vt[i].taken, vt[i].gpc, vt[i].lpc, vt[i].inc, vt[i].dec}));
      idle();
      chk("vec_hold_idx", 32'(upd_idx_o), 32'(vt[i].idx));
    end

    // Flush with 3 entries plus same-cycle resolve and allocate.
    alloc(10'h031, 12'h031, 1, 0, 1);
    alloc(10'h032, 12'h032, 0, 1, 0);
    alloc(10'h033, 12'h033, 1, 1, 1);
    cyc(1, 10'h03F, 12'h03F, 1, 1, 2'd2, 1, 1, 1, 1);
    chk("flush_upd_idx", 32'(upd_idx_o), 32'h031);
    chk("flush_count", 32'(count_o), 0);
    chk("flush_ready", 32'(alloc_ready_o), 1);
    chk("flush_no_err", 32'(err_o), 0);
    idle();
    alloc(10'h040, 12'h040, 0, 0, 1);
    resolve(1);
    chk("post_flush_idx", 32'(upd_idx_o), 32'h040);

    // Underflow: resolve on empty, and resolve with same-cycle allocate on empty.
    resolve(1);
    chk("underflow_v", 32'(upd_v_o), 0);
    chk("underflow_err", 32'(err_o), 1);
    do_reset("rst1");
    cyc(1, 10'h060, 12'h060, 1, 0, 2'd1, 1, 1, 1, 0);
    chk("no_bypass_v", 32'(upd_v_o), 0);
    chk("no_bypass_err", 32'(err_o), 1);
    resolve(0);
    chk("no_bypass_late_idx", 32'(upd_idx_o), 32'h060);

    // Fill to full, overflow drop, drain in order.
    for (int i = 1; i <= 4; i++) alloc(10'(i), 12'(i * 16), i[0], i[1], 1);
    chk("full_count", 32'(count_o), 4);
    chk("full_ready", 32'(alloc_ready_o), 0);
    alloc(10'h005, 12'h050, 1, 1, 1);
    chk("overflow_err", 32'(err_o), 1);
    for (int i = 1; i <= 4; i++) begin
      resolve(i[0]);
      chk("drain_idx", 32'(upd_idx_o), 32'(i));
    end
    chk("drain_count", 32'(count_o), 0);

    // Full with simultaneous allocate+resolve: allocate dropped, resolve proceeds.
    for (int i = 0; i < 4; i++) alloc(10'(8'h70 + i), 12'h700, 0, 1, 0);
    cyc(1, 10'h07F, 12'h7FF, 1, 1, 2'd0, 1, 1, 1, 0);
    chk("full_simul_count", 32'(count_o), 3);
    for (int i = 0; i < 3; i++) resolve(0);

    // Wrap-around: interleaved allocate+resolve, occupancy stays small.
    alloc(10'h020, 12'h200, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 10'(8'h21 + i), 12'(i), i[0], i[1], 2'd2, i[2], 1, i[0], 0);
      chk("wrap_idx", 32'(upd_idx_o), 32'(8'h20 + i));
      chk("wrap_count_le2", 32'(count_o <= 3'd2), 1);
    end
    resolve(1);
    chk("wrap_last_idx", 32'(upd_idx_o), 32'h02A);

    // Simultaneous allocate+resolve at count=2.
    alloc(10'h0B1, 12'hB01, 1, 0, 1);
    alloc(10'h0B2, 12'hB02, 0, 1, 1);
    cyc(1, 10'h0B3, 12'hB03, 1, 1, 2'd3, 0, 1, 0, 0);
    chk("simul_count", 32'(count_o), 2);
    chk("simul_head_idx", 32'(upd_idx_o), 32'h0B1);
    resolve(1);
    resolve(1);
    chk("simul_last_idx", 32'(upd_idx_o), 32'h0B3);

    // Async reset mid-stream with 2 entries and an update pulse in flight.
    alloc(10'h051, 12'h5A5, 1, 0, 1);
    alloc(10'h052, 12'h5A6, 0, 1, 1);
    alloc_v_i = 1'b0; res_v_i = 1'b1; correct_i = 1'b1; flush_i = 1'b0;
    @(posedge clk_i); #2;
    chk("pre_reset_pulse", 32'(upd_v_o), 1);
    res_v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk_reset_state("async");
    m_q.delete(); exp_q.delete(); m_err = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_reset_no_pulse", 32'(upd_v_o), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
